// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline-stage register: FSM state encoding and
// the width of the occupancy count.
package pipe_pkg;

   localparam int CNT_W = 2;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_e;

endpackage

// File: rtl/pipe_data_reg.sv
// Single payload register with load enable and synchronous clear.
// The clear input takes priority over the load input.
module pipe_data_reg #(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             i_load,
   input  logic             i_clear,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_q <= RESET_VAL;
      end else if (i_clear) begin
         r_q <= RESET_VAL;
      end else if (i_load) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake, synchronous flush and
// an optional two-entry skid buffer (SKID=1) that registers o_ready.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter bit               SKID      = 1'b1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_data,
   input  logic             i_flush,
   output logic [CNT_W-1:0] o_count
);

   // Handshake: a beat moves on a rising edge when valid and ready are both
   // high; valid never waits on ready, and o_data/o_valid hold while stalled.
   logic             w_accept;
   logic             w_take;
   logic             w_main_load;
   logic [WIDTH-1:0] w_main_d;

   assign w_accept = i_valid & o_ready;
   assign w_take   = o_valid & i_ready;

   pipe_data_reg #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
   ) u_main (
      .clk     (clk),
      .resetn  (resetn),
      .i_load  (w_main_load),
      .i_clear (i_flush),
      .i_d     (w_main_d),
      .o_q     (o_data)
   );

   generate
      if (SKID) begin : g_skid
         state_e           r_state;
         logic             r_ready;
         logic             r_valid;
         logic [CNT_W-1:0] r_count;
         logic             w_skid_load;
         logic [WIDTH-1:0] w_skid_q;

         // Main entry loads from upstream, except when draining the skid.
         assign w_main_load = ((r_state == ST_EMPTY) && w_accept) ||
                              ((r_state == ST_ONE) && w_accept && w_take) ||
                              ((r_state == ST_FULL) && w_take);
         assign w_main_d    = (r_state == ST_FULL) ? w_skid_q : i_data;
         assign w_skid_load = (r_state == ST_ONE) && w_accept && !w_take;

         pipe_data_reg #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
         ) u_skid (
            .clk     (clk),
            .resetn  (resetn),
            .i_load  (w_skid_load),
            .i_clear (i_flush),
            .i_d     (i_data),
            .o_q     (w_skid_q)
         );

         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
               r_state <= ST_EMPTY;
               r_ready <= 1'b1;
               r_valid <= 1'b0;
               r_count <= CNT_W'(0);
            end else if (i_flush) begin
               r_state <= ST_EMPTY;
               r_ready <= 1'b1;
               r_valid <= 1'b0;
               r_count <= CNT_W'(0);
            end else begin
               case (r_state)
                  ST_EMPTY: begin
                     if (w_accept) begin
                        r_state <= ST_ONE;
                        r_valid <= 1'b1;
                        r_count <= CNT_W'(1);
                     end
                  end
                  ST_ONE: begin
                     if (w_accept && !w_take) begin
                        r_state <= ST_FULL;
                        r_ready <= 1'b0;
                        r_count <= CNT_W'(2);
                     end else if (!w_accept && w_take) begin
                        r_state <= ST_EMPTY;
                        r_valid <= 1'b0;
                        r_count <= CNT_W'(0);
                     end
                  end
                  ST_FULL: begin
                     if (w_take) begin
                        r_state <= ST_ONE;
                        r_ready <= 1'b1;
                        r_count <= CNT_W'(1);
                     end
                  end
                  default: begin
                     r_state <= ST_EMPTY;
                     r_ready <= 1'b1;
                     r_valid <= 1'b0;
                     r_count <= CNT_W'(0);
                  end
               endcase
            end
         end

         assign o_ready = r_ready;
         assign o_valid = r_valid;
         assign o_count = r_count;
      end else begin : g_single
         logic r_valid;

         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
               r_valid <= 1'b0;
            end else if (i_flush) begin
               r_valid <= 1'b0;
            end else if (w_accept) begin
               r_valid <= 1'b1;
            end else if (w_take) begin
               r_valid <= 1'b0;
            end
         end

         assign w_main_load = w_accept;
         assign w_main_d    = i_data;
         assign o_ready     = !r_valid | i_ready;
         assign o_valid     = r_valid;
         assign o_count     = CNT_W'(r_valid);
      end
   endgenerate

endmodule
